// File: rtl/dma_pkg.sv
// Shared definitions for the word-copy DMA engine: register offsets, control/status
// bit positions and the engine state encoding.
package dma_pkg;

  localparam logic [4:0] DMA_SRC  = 5'h00;
  localparam logic [4:0] DMA_DST  = 5'h04;
  localparam logic [4:0] DMA_LEN  = 5'h08;
  localparam logic [4:0] DMA_CTRL = 5'h0C;
  localparam logic [4:0] DMA_STAT = 5'h10;
  localparam logic [4:0] DMA_CLR  = 5'h14;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StDone
  } dma_state_t;

endpackage

// File: rtl/dma_regfile.sv
// MMIO register window of the DMA engine: decode, storage, done/irq bookkeeping and
// registered readback.
module dma_regfile
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_we,
  input  logic [4:0]        s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  input  logic              idle,
  input  logic              busy,
  input  logic              done_set,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              start,
  output logic              irq
);

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              irq_en_q;
  logic              done_q, done_d;
  logic              wr, rd;
  logic              wr_src, wr_dst, wr_len, wr_ctrl, wr_clr;
  logic [DATA_W-1:0] rdata_d;

  assign wr      = s_valid & s_we;
  assign rd      = s_valid & ~s_we;
  assign wr_src  = wr && (s_addr == DMA_SRC);
  assign wr_dst  = wr && (s_addr == DMA_DST);
  assign wr_len  = wr && (s_addr == DMA_LEN);
  assign wr_ctrl = wr && (s_addr == DMA_CTRL);
  assign wr_clr  = wr && (s_addr == DMA_CLR);

  // A start is only honoured from idle; while a copy runs the bit is dropped.
  assign start = wr_ctrl & s_wdata[CTRL_START] & idle;

  assign src = src_q;
  assign dst = dst_q;
  assign len = len_q;
  assign irq = done_q & irq_en_q;

  // Later assignments take priority: a CLR in the completion cycle leaves done at 0.
  always_comb begin
    done_d = done_q;
    if (start)    done_d = 1'b0;
    if (done_set) done_d = 1'b1;
    if (wr_clr)   done_d = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    case (s_addr)
      DMA_SRC:  rdata_d = DATA_W'(src_q);
      DMA_DST:  rdata_d = DATA_W'(dst_q);
      DMA_LEN:  rdata_d = DATA_W'(len_q);
      DMA_CTRL: rdata_d = {{(DATA_W-2){1'b0}}, irq_en_q, 1'b0};
      DMA_STAT: rdata_d = {{(DATA_W-2){1'b0}}, done_q, busy};
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
    end else begin
      if (wr_src && !busy) src_q <= {s_wdata[ADDR_W-1:2], 2'b00};
      if (wr_dst && !busy) dst_q <= {s_wdata[ADDR_W-1:2], 2'b00};
      if (wr_len && !busy) len_q <= s_wdata[LEN_W-1:0];
      if (wr_ctrl)         irq_en_q <= s_wdata[CTRL_IRQ_EN];
      done_q   <= done_d;
      s_rvalid <= rd;
      if (rd) s_rdata <= rdata_d;
    end
  end

endmodule

// File: rtl/dma_copy_engine.sv
// Memory-to-memory word-copy DMA master: MMIO-programmed, one outstanding read at a time,
// level interrupt on completion.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_we,
  input  logic [4:0]        s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              irq
);

  localparam int unsigned WordBytes = DATA_W / 8;

  dma_state_t        state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] cur_src_q, cur_dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;
  logic              start;
  logic [ADDR_W-1:0] next_src;

  assign next_src = cur_src_q + ADDR_W'(WordBytes);

  dma_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid),
    .idle     (state_q == StIdle),
    .busy     (busy_q),
    .done_set (state_q == StDone),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .start    (start),
    .irq      (irq)
  );

  // m_wdata doubles as the read-data buffer between the read and write beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cur_src_q <= src;
            cur_dst_q <= dst;
            rem_q     <= {len[LEN_W-1:2], 2'b00};
            if (len[LEN_W-1:2] == '0) begin
              state_q <= StDone;
            end else begin
              busy_q  <= 1'b1;
              m_req   <= 1'b1;
              m_we    <= 1'b0;
              m_addr  <= src;
              state_q <= StRdReq;
            end
          end
        end
        StRdReq: begin
          if (m_gnt) begin
            m_req   <= 1'b0;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          if (m_rvalid) begin
            m_wdata <= m_rdata;
            m_req   <= 1'b1;
            m_we    <= 1'b1;
            m_addr  <= cur_dst_q;
            state_q <= StWrReq;
          end
        end
        StWrReq: begin
          if (m_gnt) begin
            cur_src_q <= next_src;
            cur_dst_q <= cur_dst_q + ADDR_W'(WordBytes);
            rem_q     <= rem_q - LEN_W'(WordBytes);
            if (rem_q == LEN_W'(WordBytes)) begin
              m_req   <= 1'b0;
              state_q <= StDone;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= next_src;
              state_q <= StRdReq;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          m_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: a memory slave with configurable stall and read
// latency, and a scoreboard of expected beats derived from the copy parameters.
module tb_dma_copy_engine;

  localparam logic [4:0] A_SRC  = 5'h00;
  localparam logic [4:0] A_DST  = 5'h04;
  localparam logic [4:0] A_LEN  = 5'h08;
  localparam logic [4:0] A_CTRL = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;
  localparam logic [4:0] A_CLR  = 5'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_we = 1'b0;
  logic [4:0]  s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        irq;

  dma_copy_engine #(
    .ADDR_W (32),
    .DATA_W (32),
    .LEN_W  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int          total = 0;
  int          bad = 0;
  beat_t       exp_q[$];
  logic [31:0] mem [int unsigned];

  int          stall_cfg = 0;
  int          rv_lat = 1;
  int          stall_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] rv_data = '0;
  int          rd_grants = 0;
  int          wr_grants = 0;
  bit          prev_stall = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  // Expected beat stream: alternating read of src word i and write of that word to dst.
  task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] len);
    beat_t b;
    for (int i = 0; i < int'(len[15:2]); i++) begin
      b.we = 1'b0; b.addr = src + 32'(4 * i); b.data = '0;
      exp_q.push_back(b);
      b.we = 1'b1; b.addr = dst + 32'(4 * i); b.data = mem_rd(src + 32'(4 * i));
      exp_q.push_back(b);
    end
  endtask

  // Memory slave and beat scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    m_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = rv_data;
      end
    end
    if (prev_stall && !rst) begin
      check("stall_req",   32'(m_req), 32'd1);
      check("stall_we",    32'(m_we),  32'(prev_we));
      check("stall_addr",  m_addr,     prev_addr);
      check("stall_wdata", m_wdata,    prev_wdata);
    end
    m_gnt = 1'b0;
    if (m_req && !rst) begin
      if (stall_cnt >= stall_cfg) begin
        m_gnt = 1'b1;
        stall_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_we",   32'(m_we), 32'(e.we));
          check("beat_addr", m_addr,    e.addr);
          if (e.we) check("beat_wdata", m_wdata, e.data);
        end
        if (!m_we) begin
          rd_grants++;
          rv_cnt  = rv_lat;
          rv_data = mem_rd(m_addr);
        end else begin
          wr_grants++;
          mem[m_addr] = m_wdata;
        end
      end else begin
        stall_cnt++;
      end
    end else begin
      stall_cnt = 0;
    end
    prev_stall = m_req && !m_gnt && !rst;
    prev_we    = m_we;
    prev_addr  = m_addr;
    prev_wdata = m_wdata;
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_we = 1'b1; s_addr = a; s_wdata = d;
    @(negedge clk);
    s_valid = 1'b0; s_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_we = 1'b0; s_addr = a;
    @(negedge clk);
    s_valid = 1'b0;
    check("s_rvalid", 32'(s_rvalid), 32'd1);
    d = s_rdata;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] st;
    int n;
    st = '0;
    n = 0;
    while (!st[1] && n < 300) begin
      bus_read(A_STAT, st);
      n++;
    end
    check(name, 32'(st[1]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int rb, wb, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_req",    32'(m_req),    32'd0);
    check("rst_irq",      32'(irq),      32'd0);
    check("rst_s_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_s_rdata",  s_rdata,       32'd0);
    rst = 1'b0;
    bus_read(A_SRC, rd);  check("rst_src",  rd, 32'd0);
    bus_read(A_STAT, rd); check("rst_stat", rd, 32'd0);

    // 1: basic four-word copy
    mem[32'h200] = 32'h1111_1111; mem[32'h204] = 32'h2222_2222;
    mem[32'h208] = 32'h3333_3333; mem[32'h20C] = 32'h4444_4444;
    bus_write(A_SRC, 32'h200);
    bus_write(A_DST, 32'h300);
    bus_write(A_LEN, 32'h10);
    expect_copy(32'h200, 32'h300, 32'h10);
    rb = rd_grants; wb = wr_grants;
    bus_write(A_CTRL, 32'd3);
    wait_done("t1_done");
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_reads",   32'(rd_grants - rb), 32'd4);
    check("t1_writes",  32'(wr_grants - wb), 32'd4);
    check("t1_mem300", mem_rd(32'h300), 32'h1111_1111);
    check("t1_mem304", mem_rd(32'h304), 32'h2222_2222);
    check("t1_mem308", mem_rd(32'h308), 32'h3333_3333);
    check("t1_mem30c", mem_rd(32'h30C), 32'h4444_4444);
    bus_read(A_STAT, rd); check("t1_stat", rd, 32'd2);
    check("t1_irq", 32'(irq), 32'd1);
    bus_read(A_LEN, rd); check("t1_len_kept", rd, 32'h10);
    bus_write(A_CLR, 32'd0);
    check("t1_irq_clr", 32'(irq), 32'd0);
    bus_read(A_STAT, rd); check("t1_stat_clr", rd, 32'd0);

    // 2: zero-length copy
    bus_write(A_LEN, 32'd0);
    rb = rd_grants; wb = wr_grants;
    bus_write(A_CTRL, 32'd3);
    @(negedge clk);
    check("t2_irq", 32'(irq), 32'd1);
    bus_read(A_STAT, rd); check("t2_stat", rd, 32'd2);
    check("t2_no_beats", 32'((rd_grants - rb) + (wr_grants - wb)), 32'd0);
    bus_write(A_CLR, 32'd0);

    // 3: five-cycle grant stall, read latency 3
    stall_cfg = 5; rv_lat = 3;
    for (int i = 0; i < 3; i++) mem[32'h600 + 32'(4 * i)] = 32'hA5A5_0000 + 32'(i);
    bus_write(A_SRC, 32'h600);
    bus_write(A_DST, 32'h700);
    bus_write(A_LEN, 32'h0C);
    expect_copy(32'h600, 32'h700, 32'h0C);
    bus_write(A_CTRL, 32'd3);
    wait_done("t3_done");
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    check("t3_mem700", mem_rd(32'h700), 32'hA5A5_0000);
    check("t3_mem708", mem_rd(32'h708), 32'hA5A5_0002);
    bus_write(A_CLR, 32'd0);

    // 4: reprogramming and restart while busy are ignored
    stall_cfg = 2; rv_lat = 1;
    for (int i = 0; i < 4; i++) mem[32'h800 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);
    mem[32'h500] = 32'hBAD0_0500;
    bus_write(A_SRC, 32'h800);
    bus_write(A_DST, 32'h900);
    bus_write(A_LEN, 32'h10);
    expect_copy(32'h800, 32'h900, 32'h10);
    bus_write(A_CTRL, 32'd3);
    bus_read(A_STAT, rd); check("t4_busy", 32'(rd[0]), 32'd1);
    bus_write(A_SRC, 32'h500);
    bus_write(A_CTRL, 32'd3);
    bus_read(A_SRC, rd); check("t4_src_kept", rd, 32'h800);
    wait_done("t4_done");
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    check("t4_mem90c", mem_rd(32'h90C), 32'hC0DE_0003);
    bus_write(A_CLR, 32'd0);
    repeat (40) @(negedge clk);
    bus_read(A_STAT, rd); check("t4_single_done", rd, 32'd0);

    // 5: completion with irq disabled, then enable
    stall_cfg = 0;
    mem[32'hA00] = 32'h5A5A_1234;
    bus_write(A_SRC, 32'hA00);
    bus_write(A_DST, 32'hB00);
    bus_write(A_LEN, 32'h4);
    expect_copy(32'hA00, 32'hB00, 32'h4);
    bus_write(A_CTRL, 32'd1);
    wait_done("t5_done");
    check("t5_irq_off", 32'(irq), 32'd0);
    bus_read(A_CTRL, rd); check("t5_ctrl0", rd, 32'd0);
    bus_write(A_CTRL, 32'd2);
    check("t5_irq_on", 32'(irq), 32'd1);
    bus_read(A_CTRL, rd); check("t5_ctrl2", rd, 32'd2);
    bus_read(A_STAT, rd); check("t5_stat", rd, 32'd2);
    check("t5_mem", mem_rd(32'hB00), 32'h5A5A_1234);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset after the second read grant
    bus_write(A_CLR, 32'd0);
    stall_cfg = 1; rv_lat = 3;
    for (int i = 0; i < 4; i++) mem[32'hC00 + 32'(4 * i)] = 32'h7700_0000 + 32'(i);
    bus_write(A_SRC, 32'hC00);
    bus_write(A_DST, 32'hD00);
    bus_write(A_LEN, 32'h10);
    expect_copy(32'hC00, 32'hD00, 32'h10);
    rb = rd_grants; wb = wr_grants;
    bus_write(A_CTRL, 32'd3);
    n = 0;
    while (rd_grants < rb + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_second_read", 32'(rd_grants - rb), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    check("t6_writes_before", 32'(wr_grants - wb), 32'd1);
    wb = wr_grants;
    repeat (2) @(negedge clk);
    check("t6_rst_req", 32'(m_req), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_idle_req", 32'(m_req), 32'd0);
    end
    check("t6_no_writes", 32'(wr_grants - wb), 32'd0);
    check("t6_mem_d00", mem_rd(32'hD00), 32'h7700_0000);
    bus_read(A_SRC, rd);  check("t6_src",  rd, 32'd0);
    bus_read(A_DST, rd);  check("t6_dst",  rd, 32'd0);
    bus_read(A_LEN, rd);  check("t6_len",  rd, 32'd0);
    bus_read(A_CTRL, rd); check("t6_ctrl", rd, 32'd0);
    bus_read(A_STAT, rd); check("t6_stat", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
